// File: rtl/tmr_intc_pkg.sv
// Shared definitions for the timer interrupt controller: source indices and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package tmr_intc_pkg;

  // Bit positions of the timer interrupt sources on i_irq / o_pending / o_clr_flag.
  localparam int SRC_CMIA0 = 0;
  localparam int SRC_CMIB0 = 1;
  localparam int SRC_OVI0  = 2;
  localparam int SRC_CMIA1 = 3;
  localparam int SRC_CMIB1 = 4;
  localparam int SRC_OVI1  = 5;

  // Request handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CLR  = 2'd2,
    TOUT = 2'd3
  } state_t;

endpackage

// File: rtl/posedge_detector.sv
// Single-bit rising-edge detector with a registered history bit.
// Latency: o_rise is combinational from i_sig; history updates every clock.
// Backpressure: none.
// Ports: i_clk, i_rst_n (async active-low), i_sig (level in), o_rise (high while i_sig=1 and last sample=0).
module posedge_detector (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/tmr_intc_arbiter.sv
// Combinational pick of one pending source, searching upward from i_start with wrap-around.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_pend (pending vector), i_start (first index searched), o_idx (winner), o_vld (any pending).
module tmr_intc_arbiter #(
  parameter int NUM_SRC = 6,
  parameter int VEC_W   = 3
) (
  input  logic [NUM_SRC-1:0] i_pend,
  input  logic [VEC_W-1:0]   i_start,
  output logic [VEC_W-1:0]   o_idx,
  output logic               o_vld
);

  int w_dist;
  int w_best;

  // Each source's distance from the start point (modulo NUM_SRC) is its
  // priority; the pending source with the smallest distance wins. With
  // i_start tied to 0 this is plain lowest-index-wins.
  always_comb begin
    o_idx  = '0;
    o_vld  = 1'b0;
    w_dist = 0;
    w_best = NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_dist = i - int'(i_start);
      if (w_dist < 0) begin
        w_dist = w_dist + NUM_SRC;
      end
      if (i_pend[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = VEC_W'(i);
        o_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmr_intc.sv
// Timer interrupt controller: edge-captures six IRQ lines, arbitrates, runs a req/ack handshake, pulses flag-clear.
// Latency: rising i_irq before edge t0 -> o_irq_req after edge t1; ack -> o_clr_flag pulse the next cycle.
// Backpressure: request is held until i_irq_ack or ACK_TIMEOUT cycles elapse; new edges keep accumulating in o_pending.
// Ports: i_clk, i_rst_n (async active-low), i_irq[NUM_SRC], i_int_en, i_irq_ack,
//        o_irq_req, o_irq_vec[VEC_W], o_clr_flag[NUM_SRC], o_pending[NUM_SRC], o_timeout.
// Build option: define TMR_INTC_ROUND_ROBIN_EN for rotating priority (search starts after the last acked source).
module tmr_intc
  import tmr_intc_pkg::*;
#(
  parameter int NUM_SRC     = 6,
  parameter int VEC_W       = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_irq,
  input  logic               i_int_en,
  input  logic               i_irq_ack,
  output logic               o_irq_req,
  output logic [VEC_W-1:0]   o_irq_vec,
  output logic [NUM_SRC-1:0] o_clr_flag,
  output logic [NUM_SRC-1:0] o_pending,
  output logic               o_timeout
);

  // $clog2(1) is 0, so a disabled timeout still gets a 1-bit counter.
  localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] w_clr_mask;
  logic [NUM_SRC-1:0] w_vec_onehot;
  logic [VEC_W-1:0]   r_vec;
  logic [VEC_W-1:0]   w_start;
  logic [VEC_W-1:0]   w_arb_idx;
  logic               w_arb_vld;
  logic               w_tout_hit;
  logic [CNT_W-1:0]   r_cnt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_edge
    posedge_detector u_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (i_irq[g]),
      .o_rise  (w_rise[g])
    );
  end

`ifdef TMR_INTC_ROUND_ROBIN_EN
  // Last-served pointer; only an acknowledged service moves it, a timeout does not.
  logic [VEC_W-1:0] r_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if ((r_state == REQ) && i_irq_ack) begin
      r_ptr <= r_vec;
    end
  end

  assign w_start = (r_ptr == VEC_W'(NUM_SRC - 1)) ? '0 : (r_ptr + VEC_W'(1));
`else
  assign w_start = '0;
`endif

  tmr_intc_arbiter #(
    .NUM_SRC (NUM_SRC),
    .VEC_W   (VEC_W)
  ) u_arb (
    .i_pend  (r_pending),
    .i_start (w_start),
    .o_idx   (w_arb_idx),
    .o_vld   (w_arb_vld)
  );

  assign w_vec_onehot = NUM_SRC'(1) << r_vec;
  assign w_tout_hit   = (ACK_TIMEOUT != 0) && (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign o_pending    = r_pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_mask  = '0;
    o_irq_req   = 1'b0;
    o_irq_vec   = '0;
    o_clr_flag  = '0;
    o_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_int_en && w_arb_vld) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        o_irq_req = 1'b1;
        o_irq_vec = r_vec;
        // Ack takes precedence over a timeout landing on the same edge.
        if (i_irq_ack) begin
          w_state_nxt = CLR;
          w_clr_mask  = w_vec_onehot;
        end else if (w_tout_hit) begin
          w_state_nxt = TOUT;
        end
      end
      CLR: begin
        o_clr_flag  = w_vec_onehot;
        w_state_nxt = IDLE;
      end
      TOUT: begin
        o_timeout   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
      r_vec     <= '0;
      r_cnt     <= '0;
    end else begin
      // A fresh edge on the source being cleared survives the clear.
      r_pending <= (r_pending & ~w_clr_mask) | w_rise;
      if ((r_state == IDLE) && (w_state_nxt == REQ)) begin
        r_vec <= w_arb_idx;
        r_cnt <= '0;
      end else if (r_state == REQ) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tmr_intc.sv
module tb_tmr_intc;
  import tmr_intc_pkg::*;

  localparam int NSRC = 6;
  localparam int VW   = 3;
  localparam int TMO  = 4;
`ifdef TMR_INTC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [NSRC-1:0] i_irq;
  logic            i_int_en;
  logic            i_irq_ack;
  logic            o_irq_req;
  logic [VW-1:0]   o_irq_vec;
  logic [NSRC-1:0] o_clr_flag;
  logic [NSRC-1:0] o_pending;
  logic            o_timeout;

  tmr_intc #(
    .NUM_SRC     (NSRC),
    .VEC_W       (VW),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_irq      (i_irq),
    .i_int_en   (i_int_en),
    .i_irq_ack  (i_irq_ack),
    .o_irq_req  (o_irq_req),
    .o_irq_vec  (o_irq_vec),
    .o_clr_flag (o_clr_flag),
    .o_pending  (o_pending),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending set, last seen input levels, and the request
  // in flight described as "waiting for ack since m_wait cycles", "just
  // cleared source m_clr" or "just abandoned".
  bit m_pend [NSRC];
  bit m_prev [NSRC];
  bit m_req;
  bit m_tout;
  int m_vec;
  int m_clr;
  int m_wait;
  int m_last;

  task automatic model_reset();
    for (int k = 0; k < NSRC; k++) begin
      m_pend[k] = 1'b0;
      m_prev[k] = 1'b0;
    end
    m_req  = 1'b0;
    m_tout = 1'b0;
    m_vec  = 0;
    m_clr  = -1;
    m_wait = 0;
    m_last = 0;
  endtask

  function automatic int pick();
    int start;
    start = RR ? (m_last + 1) % NSRC : 0;
    for (int d = 0; d < NSRC; d++) begin
      if (m_pend[(start + d) % NSRC]) return (start + d) % NSRC;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [NSRC-1:0] irq, input logic en, input logic ack);
    bit ack_now, tout_now, idle;
    bit nxt [NSRC];
    int w;
    ack_now  = m_req && ack;
    tout_now = m_req && !ack && (TMO > 0) && (m_wait == TMO - 1);
    idle     = !m_req && (m_clr < 0) && !m_tout;
    w        = pick();
    for (int k = 0; k < NSRC; k++) begin
      nxt[k]    = (m_pend[k] && !(ack_now && (k == m_vec))) || (irq[k] && !m_prev[k]);
      m_prev[k] = irq[k];
    end
    m_clr  = -1;
    m_tout = 1'b0;
    if (ack_now) begin
      m_req  = 1'b0;
      m_clr  = m_vec;
      m_last = m_vec;
    end else if (tout_now) begin
      m_req  = 1'b0;
      m_tout = 1'b1;
    end else if (m_req) begin
      m_wait++;
    end else if (idle && en && (w >= 0)) begin
      m_req  = 1'b1;
      m_vec  = w;
      m_wait = 0;
    end
    for (int k = 0; k < NSRC; k++) m_pend[k] = nxt[k];
  endtask

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < NSRC; k++) v[k] = m_pend[k];
    return v;
  endfunction

  task automatic check_all();
    chk("req",  32'(o_irq_req),  32'(m_req));
    chk("vec",  32'(o_irq_vec),  m_req ? 32'(m_vec) : 32'h0);
    chk("clr",  32'(o_clr_flag), (m_clr >= 0) ? (32'h1 << m_clr) : 32'h0);
    chk("tout", 32'(o_timeout),  32'(m_tout));
    chk("pend", 32'(o_pending),  m_pend_vec());
  endtask

  task automatic cycle(input logic [NSRC-1:0] irq, input logic en, input logic ack);
    i_irq     = irq;
    i_int_en  = en;
    i_irq_ack = ack;
    @(posedge i_clk);
    model_step(irq, en, ack);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    i_irq     = '0;
    i_int_en  = 1'b0;
    i_irq_ack = 1'b0;
    i_rst_n   = 1'b0;
    @(posedge i_clk);
    #1;
    model_reset();
    check_all();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Wait (bounded) for a request, record its vector, then acknowledge it.
  task automatic serve(input logic [NSRC-1:0] irq, output int vec);
    int n;
    n   = 0;
    vec = -1;
    while (!o_irq_req && (n < 20)) begin
      cycle(irq, 1'b1, 1'b0);
      n++;
    end
    chk("req_seen", 32'(o_irq_req), 32'h1);
    if (o_irq_req) vec = int'(o_irq_vec);
    cycle(irq, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vec;
    int n;
    int got [3];
    int exp_ord [3];
    logic [NSRC-1:0] rirq;
    logic ren, rack;

    // Reset state and single-source latency/clear.
    do_reset();
    chk("rst_pend", 32'(o_pending), 32'h0);
    cycle(6'b000000, 1'b1, 1'b0);
    cycle(6'b000100, 1'b1, 1'b0);
    chk("single_lat0", 32'(o_irq_req), 32'h0);
    cycle(6'b000100, 1'b1, 1'b0);
    chk("single_req", 32'(o_irq_req), 32'h1);
    chk("single_vec", 32'(o_irq_vec), 32'(SRC_OVI0));
    cycle(6'b000100, 1'b1, 1'b1);
    chk("single_clr", 32'(o_clr_flag), 32'h4);
    cycle(6'b000100, 1'b1, 1'b0);
    chk("single_clr_once", 32'(o_clr_flag), 32'h0);
    chk("single_pend", 32'(o_pending), 32'h0);

    // Simultaneous edges: service order depends on the arbitration mode.
    do_reset();
    if (RR) begin
      exp_ord[0] = SRC_CMIB0; exp_ord[1] = SRC_CMIB1; exp_ord[2] = SRC_CMIA0;
    end else begin
      exp_ord[0] = SRC_CMIA0; exp_ord[1] = SRC_CMIB0; exp_ord[2] = SRC_CMIB1;
    end
    for (int i = 0; i < 3; i++) begin
      serve(6'b010011, got[i]);
      chk("order", 32'(got[i]), 32'(exp_ord[i]));
    end

    // Timeout: request held TMO cycles, pulse, pending kept, request reissued.
    do_reset();
    n = 0;
    while (!o_irq_req && (n < 20)) begin
      cycle(6'b001000, 1'b1, 1'b0);
      n++;
    end
    n = 0;
    while (o_irq_req && (n < 10)) begin
      cycle(6'b001000, 1'b1, 1'b0);
      n++;
    end
    chk("tout_len", 32'(n), 32'(TMO));
    chk("tout_pulse", 32'(o_timeout), 32'h1);
    chk("tout_pend", 32'(o_pending[SRC_CMIA1]), 32'h1);
    cycle(6'b001000, 1'b1, 1'b0);
    chk("tout_idle", 32'(o_irq_req), 32'h0);
    cycle(6'b001000, 1'b1, 1'b0);
    chk("tout_reissue", 32'(o_irq_req), 32'h1);
    chk("tout_revec", 32'(o_irq_vec), 32'(SRC_CMIA1));
    cycle(6'b001000, 1'b1, 1'b1);

    // New edge on the source being cleared: set wins.
    do_reset();
    cycle(6'b000001, 1'b1, 1'b0);
    cycle(6'b000000, 1'b1, 1'b0);
    cycle(6'b000001, 1'b1, 1'b1);
    chk("setwins_clr", 32'(o_clr_flag), 32'h1);
    chk("setwins_pend", 32'(o_pending[SRC_CMIA0]), 32'h1);
    serve(6'b000001, vec);
    chk("setwins_vec", 32'(vec), 32'(SRC_CMIA0));

    // Gating: edges captured while disabled, request only after enable.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(6'b100000, 1'b0, 1'b0);
    chk("gate_pend", 32'(o_pending[SRC_OVI1]), 32'h1);
    chk("gate_noreq", 32'(o_irq_req), 32'h0);
    serve(6'b100000, vec);
    chk("gate_vec", 32'(vec), 32'(SRC_OVI1));

    // Higher-priority edge during REQ does not disturb the current vector.
    do_reset();
    n = 0;
    while (!o_irq_req && (n < 20)) begin
      cycle(6'b010000, 1'b1, 1'b0);
      n++;
    end
    cycle(6'b010010, 1'b1, 1'b0);
    chk("hold_vec", 32'(o_irq_vec), 32'(SRC_CMIB1));
    cycle(6'b010010, 1'b1, 1'b1);
    serve(6'b010010, vec);
    chk("next_vec", 32'(vec), 32'(SRC_CMIB0));

    // Reset asserted mid-handshake.
    do_reset();
    cycle(6'b000001, 1'b1, 1'b0);
    cycle(6'b000001, 1'b1, 1'b0);
    chk("mid_req_up", 32'(o_irq_req), 32'h1);
    #2;
    i_irq_ack = 1'b1;
    i_rst_n   = 1'b0;
    #1;
    chk("mid_rst_req", 32'(o_irq_req), 32'h0);
    chk("mid_rst_pend", 32'(o_pending), 32'h0);
    chk("mid_rst_clr", 32'(o_clr_flag), 32'h0);
    @(posedge i_clk);
    #1;
    chk("mid_rst_noclr", 32'(o_clr_flag), 32'h0);
    model_reset();
    check_all();
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Randomized traffic against the model.
    do_reset();
    rirq = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NSRC; k++) begin
        if ($urandom_range(0, 7) == 0) rirq[k] = ~rirq[k];
      end
      ren  = ($urandom_range(0, 9) != 0);
      rack = o_irq_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      cycle(rirq, ren, rack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
